mouse_packet_tx: RTL and testbench
==================================

// Module: mouse_packet_tx
// PURPOSE
//  Device-side PS/2 mouse transmitter. Encodes one movement/button report (9-bit X, 9-bit Y, 3 buttons) into
//  a standard 3-byte mouse packet and sends it device-to-host. It generates the PS/2 clock itself and drives
//  ps2c/ps2d open-drain. Serves as the stimulus end for the mouse receiver path and as a board-level mouse emulator.
// PARAMETERS
//  CLK_HZ   50_000_000  system clock frequency in Hz
//  HALF_US  40          PS/2 clock half-period in us; HALF = CLK_HZ/1_000_000*HALF_US cycles (2000 at default)
//  GAP_US   100         bus-idle time in us required before each byte; GAP = CLK_HZ/1_000_000*GAP_US cycles
// PORTS
//  clk           in     1  system clock, all logic on rising edge
//  reset         in     1  asynchronous, active-low reset
//  ps2c          inout  1  PS/2 clock, open-drain: driven 0 or released to 1'bz
//  ps2d          inout  1  PS/2 data, open-drain: driven 0 or released to 1'bz
//  xm            in     9  X movement, two's complement, captured on m_start
//  ym            in     9  Y movement, two's complement, captured on m_start
//  btnm          in     3  {middle,right,left}, 1 = pressed, captured on m_start
//  m_start       in     1  request to send one packet; sampled only in IDLE
//  m_busy        out    1  high from the cycle after an accepted m_start until DONE/abort
//  m_done_tick   out    1  1-cycle pulse: all 3 bytes sent
//  m_abort_tick  out    1  1-cycle pulse: host inhibit/request seen, packet discarded
// BEHAVIOUR
//  Reset (reset=0): state IDLE, ps2c/ps2d released (z), m_busy=0, both ticks 0, all counters 0.
//  Packet: b0={2'b00, ym[8], xm[8], 1'b1, btnm[2:0]}; b1=xm[7:0]; b2=ym[7:0]. Overflow bits are always 0.
//  Frame per byte, 11 bits: start 0, d0..d7 LSB first, odd parity (~^byte), stop 1.
//  FSM states:
//   IDLE:  lines released. If m_start=1: capture xm/ym/btnm into regs, byte_idx=0, go WAIT_BUS. Else stay.
//   WAIT_BUS: lines released. Timer counts consecutive cycles with ps2c=1 and ps2d=1.
//    Either line low resets the timer. If ps2d is low while the bus is otherwise idle, the host is requesting to
//    send: abort. At GAP go to BIT_HI with bit_idx=0.
//   BIT_HI: ps2d driven to the current bit (0 -> drive 0, 1 -> release); ps2c released for HALF cycles.
//    On the last cycle, sample ps2c: if 0, the host is inhibiting, so abort. Else go to BIT_LO.
//   BIT_LO: ps2c driven 0 for HALF cycles, ps2d held. The host samples on this falling edge.
//    At end: if bit_idx<10 then bit_idx++ and go to BIT_HI. Else release both lines; if byte_idx<2 then
//    byte_idx++ and go to WAIT_BUS, else go to DONE.
//   DONE:  m_done_tick=1 for one cycle, go to IDLE.
//   Abort: release both lines, m_abort_tick=1 for one cycle, go to IDLE. Captured data is dropped, no retry.
//  The ps2d value changes only at entry to BIT_HI, never while ps2c is low.
//  Timing: one byte = 22*HALF cycles after the gap. m_busy deasserts in the same cycle as the done/abort tick.
//  m_start while m_busy=1 is ignored (no queueing). m_start in the DONE cycle is ignored.
//  Async reset mid-frame releases both lines immediately, in the same cycle as the reset assertion.
//  All ps2 output enables are registered: no combinational path from inputs to the pads.
// TESTING (bench: CLK_HZ=1_000_000, HALF_US=4 -> HALF=4, GAP_US=8 -> GAP=8; host model with pull-ups)
//  1. xm=9'h005, ym=9'h1FE, btnm=3'b001, pulse m_start -> host receives 0x29 (par 0), 0x05 (par 1),
//     0xFE (par 0), each frame 88 cycles; then m_done_tick once and m_busy=0.
//  2. xm=9'h100, ym=0, btnm=3'b110 -> b0=0x1E, b1=0x00 (par 1), b2=0x00; stop bits all 1; framing correct.
//  3. Host pulls ps2c low during the 4th bit of b1 -> abort at the end of that BIT_HI; m_abort_tick once;
//     lines z; no m_done_tick.
//  4. Host holds ps2c low before a packet -> the FSM waits in WAIT_BUS indefinitely. Release -> first start bit
//     comes exactly GAP+0 cycles after release.
//  5. Second m_start pulsed while m_busy=1 -> ignored; exactly 3 bytes sent; captured values unchanged even if
//     xm/ym change mid-packet.
//  6. Drive reset=0 mid-b2 -> lines z, m_busy=0 in the same cycle. After reset=1, idle until the next m_start.

Source files
------------

// File: rtl/mouse_packet_tx.sv
`timescale 1ns/1ps
// mouse_packet_tx: device-side PS/2 mouse transmitter.
// Captures one X/Y/button report, builds the 3-byte mouse packet and clocks it
// out to the host on open-drain ps2c/ps2d, generating the PS/2 clock locally.
// Host inhibit (ps2c held low) or a host request-to-send (ps2d low on an
// otherwise idle bus) discards the packet and reports an abort.
module mouse_packet_tx #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int HALF_US = 40,
  parameter int GAP_US  = 100
) (
  input  logic       clk,
  input  logic       reset,         // asynchronous, active low
  inout  wire        ps2c,
  inout  wire        ps2d,
  input  logic [8:0] xm,
  input  logic [8:0] ym,
  input  logic [2:0] btnm,
  input  logic       m_start,
  output logic       m_busy,
  output logic       m_done_tick,
  output logic       m_abort_tick
);

  // Cycle counts derived from the clock frequency
  localparam int HALF = CLK_HZ / 1_000_000 * HALF_US;
  localparam int GAP  = CLK_HZ / 1_000_000 * GAP_US;
  localparam int TMAX = (HALF > GAP) ? HALF : GAP;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] HALF_LAST = TW'(HALF - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP - 1);
  localparam logic [3:0]    BIT_LAST  = 4'd10;  // stop bit index
  localparam logic [1:0]    BYTE_LAST = 2'd2;   // third packet byte

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BUS,
    S_BIT_HI,
    S_BIT_LO,
    S_DONE,
    S_ABORT
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_next;
  logic [3:0]    r_bit_idx;
  logic [3:0]    w_bit_idx_next;
  logic [1:0]    r_byte_idx;
  logic [1:0]    w_byte_idx_next;
  logic          w_capture;

  logic [8:0]    r_xm;
  logic [8:0]    r_ym;
  logic [2:0]    r_btn;

  // Registered pad pull-down enables; a released pad floats to the pull-up
  logic          r_c_low;
  logic          r_d_low;
  logic          w_d_low_next;

  logic          w_c_in;
  logic          w_d_in;

  logic [7:0]    w_byte  [3];
  logic [10:0]   w_frame [3];
  logic [10:0]   w_next_frame;
  logic          w_next_bit;

  // Open-drain pads: only ever pull low, otherwise release
  assign ps2c   = r_c_low ? 1'b0 : 1'bz;
  assign ps2d   = r_d_low ? 1'b0 : 1'bz;
  assign w_c_in = ps2c;
  assign w_d_in = ps2d;

  // Standard mouse packet; overflow bits are never set
  assign w_byte[0] = {2'b00, r_ym[8], r_xm[8], 1'b1, r_btn};
  assign w_byte[1] = r_xm[7:0];
  assign w_byte[2] = r_ym[7:0];

  // Each byte becomes an 11-bit frame sent LSB first: start, data, odd parity, stop
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_frame
      assign w_frame[gi] = {1'b1, ~^w_byte[gi], w_byte[gi], 1'b0};
    end
  endgenerate

  // Pick the frame and bit that will be on the data line after this edge
  always_comb begin
    w_next_frame = w_frame[0];
    case (w_byte_idx_next)
      2'd1:    w_next_frame = w_frame[1];
      2'd2:    w_next_frame = w_frame[2];
      default: w_next_frame = w_frame[0];
    endcase
    w_next_bit = w_next_frame[w_bit_idx_next];
  end

  // Next-state logic: bus gap wait, two half-periods per bit, abort on host activity
  always_comb begin
    w_state_next    = r_state;
    w_timer_next    = r_timer;
    w_bit_idx_next  = r_bit_idx;
    w_byte_idx_next = r_byte_idx;
    w_capture       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (m_start) begin
          w_capture       = 1'b1;
          w_byte_idx_next = 2'd0;
          w_bit_idx_next  = 4'd0;
          w_timer_next    = '0;
          w_state_next    = S_WAIT_BUS;
        end
      end
      S_WAIT_BUS: begin
        if (w_c_in && w_d_in) begin
          if (r_timer == GAP_LAST) begin
            w_timer_next   = '0;
            w_bit_idx_next = 4'd0;
            w_state_next   = S_BIT_HI;
          end else begin
            w_timer_next = r_timer + TW'(1);
          end
        end else begin
          // Any low line restarts the idle count; data low with clock high
          // is a host request-to-send, which takes priority over our packet
          w_timer_next = '0;
          if (w_c_in && !w_d_in) begin
            w_state_next = S_ABORT;
          end
        end
      end
      S_BIT_HI: begin
        if (r_timer == HALF_LAST) begin
          w_timer_next = '0;
          // Clock still low at the end of our high phase means host inhibit
          if (!w_c_in) begin
            w_state_next = S_ABORT;
          end else begin
            w_state_next = S_BIT_LO;
          end
        end else begin
          w_timer_next = r_timer + TW'(1);
        end
      end
      S_BIT_LO: begin
        if (r_timer == HALF_LAST) begin
          w_timer_next = '0;
          if (r_bit_idx < BIT_LAST) begin
            w_bit_idx_next = r_bit_idx + 4'd1;
            w_state_next   = S_BIT_HI;
          end else if (r_byte_idx < BYTE_LAST) begin
            w_bit_idx_next  = 4'd0;
            w_byte_idx_next = r_byte_idx + 2'd1;
            w_state_next    = S_WAIT_BUS;
          end else begin
            w_state_next = S_DONE;
          end
        end else begin
          w_timer_next = r_timer + TW'(1);
        end
      end
      S_DONE, S_ABORT: begin
        w_timer_next    = '0;
        w_bit_idx_next  = 4'd0;
        w_byte_idx_next = 2'd0;
        w_state_next    = S_IDLE;
      end
      default: begin
        w_timer_next    = '0;
        w_bit_idx_next  = 4'd0;
        w_byte_idx_next = 2'd0;
        w_state_next    = S_IDLE;
      end
    endcase
  end

  // Data pull-down follows the bit of the upcoming BIT_HI/BIT_LO phase; it is
  // only recomputed on entry to BIT_HI, so it stays put while the clock is low
  always_comb begin
    w_d_low_next = 1'b0;
    if ((w_state_next == S_BIT_HI) || (w_state_next == S_BIT_LO)) begin
      w_d_low_next = ~w_next_bit;
    end
  end

  // State and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_bit_idx  <= 4'd0;
      r_byte_idx <= 2'd0;
    end else begin
      r_state    <= w_state_next;
      r_timer    <= w_timer_next;
      r_bit_idx  <= w_bit_idx_next;
      r_byte_idx <= w_byte_idx_next;
    end
  end

  // Report capture on an accepted start; held for the whole packet
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_xm  <= '0;
      r_ym  <= '0;
      r_btn <= '0;
    end else if (w_capture) begin
      r_xm  <= xm;
      r_ym  <= ym;
      r_btn <= btnm;
    end
  end

  // Pad enables registered so nothing combinational reaches the pins;
  // reset clears them immediately, releasing both lines
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_c_low <= 1'b0;
      r_d_low <= 1'b0;
    end else begin
      r_c_low <= (w_state_next == S_BIT_LO);
      r_d_low <= w_d_low_next;
    end
  end

  // Status outputs decode the state register directly
  assign m_busy       = (r_state == S_WAIT_BUS) || (r_state == S_BIT_HI) ||
                        (r_state == S_BIT_LO);
  assign m_done_tick  = (r_state == S_DONE);
  assign m_abort_tick = (r_state == S_ABORT);

endmodule

// File: tb/tb_mouse_packet_tx.sv
`timescale 1ns/1ps
// Directed bench for mouse_packet_tx with a pulled-up host model that
// captures frames on falling ps2c edges. HALF=4, GAP=8 cycles, 10 ns clock.
module tb_mouse_packet_tx;

  localparam int CP = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [8:0] xm = '0;
  logic [8:0] ym = '0;
  logic [2:0] btnm = '0;
  logic       m_start = 1'b0;
  logic       m_busy;
  logic       m_done_tick;
  logic       m_abort_tick;

  wire        ps2c_w;
  wire        ps2d_w;
  logic       host_c_low = 1'b0;
  logic       host_d_low = 1'b0;

  assign ps2c_w = host_c_low ? 1'b0 : 1'bz;
  assign ps2d_w = host_d_low ? 1'b0 : 1'bz;
  pullup (ps2c_w);
  pullup (ps2d_w);

  mouse_packet_tx #(
    .CLK_HZ (1_000_000),
    .HALF_US(4),
    .GAP_US (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2c        (ps2c_w),
    .ps2d        (ps2d_w),
    .xm          (xm),
    .ym          (ym),
    .btnm        (btnm),
    .m_start     (m_start),
    .m_busy      (m_busy),
    .m_done_tick (m_done_tick),
    .m_abort_tick(m_abort_tick)
  );

  always #(CP/2) clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int abort_cnt = 0;

  logic [10:0] rx_frames[$];
  time         rx_first_t[$];
  time         rx_last_t[$];

  // Count tick pulses
  always @(posedge clk) begin
    if (m_done_tick)  done_cnt  <= done_cnt + 1;
    if (m_abort_tick) abort_cnt <= abort_cnt + 1;
  end

  // Host receiver: shift ps2d on each ps2c fall; a long silence drops a partial frame
  initial begin : host_rx
    logic [10:0] sh;
    int          n;
    time         last_t;
    time         first_t;
    sh = '0;
    n = 0;
    last_t = 0;
    first_t = 0;
    forever begin
      @(negedge ps2c_w);
      if (n != 0 && ($time - last_t) > 300) n = 0;
      if (n == 0) first_t = $time;
      sh = {ps2d_w, sh[10:1]};
      n++;
      last_t = $time;
      if (n == 11) begin
        rx_frames.push_back(sh);
        rx_first_t.push_back(first_t);
        rx_last_t.push_back($time);
        $display("host rx frame %0d: data=%02h par=%0b start=%0b stop=%0b",
                 rx_frames.size() - 1, sh[8:1], sh[9], sh[0], sh[10]);
        n = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] frame_at(input int idx);
    if (idx < rx_frames.size()) return rx_frames[idx];
    return 11'h000;
  endfunction

  task automatic check_frame(input string tag, input int idx, input logic [7:0] exp_b, input logic exp_p);
    logic [10:0] fr;
    fr = frame_at(idx);
    check({tag, "_data"}, 32'(fr[8:1]), 32'(exp_b));
    check({tag, "_par"},  32'(fr[9]),   32'(exp_p));
    check({tag, "_frm"},  32'({fr[10], fr[0]}), 32'(2'b10));
  endtask

  task automatic send(input logic [8:0] x, input logic [8:0] y, input logic [2:0] b, input string tag);
    @(negedge clk);
    xm = x;
    ym = y;
    btnm = b;
    m_start = 1'b1;
    @(negedge clk);
    m_start = 1'b0;
    check({tag, "_busy"}, 32'(m_busy), 32'(1'b1));
  endtask

  task automatic wait_done(input int budget, input string tag);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    check({tag, "_done_once"}, 32'(done_cnt - d0), 32'(1));
    check({tag, "_busy_off"},  32'(m_busy), 32'(1'b0));
  endtask

  task automatic wait_falls(input int n, input int budget, input string tag);
    int   seen;
    logic prev;
    seen = 0;
    prev = ps2c_w;
    for (int i = 0; i < budget && seen < n; i++) begin
      @(negedge clk);
      if (prev && !ps2c_w) seen++;
      prev = ps2c_w;
    end
    check({tag, "_falls"}, 32'(seen), 32'(n));
  endtask

  initial begin : stim
    int n0;
    int a0;
    int d0;
    int k;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy",  32'(m_busy),       32'(1'b0));
    check("rst_done",  32'(m_done_tick),  32'(1'b0));
    check("rst_abort", 32'(m_abort_tick), 32'(1'b0));
    check("rst_c",     32'(ps2c_w),       32'(1'b1));
    check("rst_d",     32'(ps2d_w),       32'(1'b1));
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // 1: basic packet, framing and timing
    n0 = rx_frames.size();
    a0 = abort_cnt;
    send(9'h005, 9'h1FE, 3'b001, "t1");
    wait_done(600, "t1");
    check("t1_nframes", 32'(rx_frames.size() - n0), 32'(3));
    check_frame("t1_b0", n0,     8'h29, 1'b0);
    check_frame("t1_b1", n0 + 1, 8'h05, 1'b1);
    check_frame("t1_b2", n0 + 2, 8'hFE, 1'b0);
    if (rx_frames.size() - n0 == 3) begin
      check("t1_frame_span", 32'(rx_last_t[n0] - rx_first_t[n0]), 32'(80 * CP));
      check("t1_b0_to_b1",   32'(rx_first_t[n0 + 1] - rx_first_t[n0]), 32'(96 * CP));
      check("t1_b1_to_b2",   32'(rx_first_t[n0 + 2] - rx_first_t[n0 + 1]), 32'(96 * CP));
    end
    check("t1_no_abort", 32'(abort_cnt - a0), 32'(0));
    check("t1_c_idle", 32'(ps2c_w), 32'(1'b1));
    check("t1_d_idle", 32'(ps2d_w), 32'(1'b1));

    // 2: X sign bit and middle/right buttons
    repeat (20) @(negedge clk);
    n0 = rx_frames.size();
    send(9'h100, 9'h000, 3'b110, "t2");
    wait_done(600, "t2");
    check("t2_nframes", 32'(rx_frames.size() - n0), 32'(3));
    check_frame("t2_b0", n0,     8'h1E, 1'b1);
    check_frame("t2_b1", n0 + 1, 8'h00, 1'b1);
    check_frame("t2_b2", n0 + 2, 8'h00, 1'b1);

    // 5: start while busy is ignored, captured report unaffected by input changes
    repeat (20) @(negedge clk);
    n0 = rx_frames.size();
    d0 = done_cnt;
    send(9'h0AA, 9'h155, 3'b010, "t5");
    repeat (50) @(negedge clk);
    xm = 9'h1FF;
    ym = 9'h1FF;
    btnm = 3'b111;
    m_start = 1'b1;
    @(negedge clk);
    m_start = 1'b0;
    wait_done(600, "t5");
    repeat (200) @(negedge clk);
    check("t5_nframes", 32'(rx_frames.size() - n0), 32'(3));
    check("t5_ndone",   32'(done_cnt - d0), 32'(1));
    check("t5_busy",    32'(m_busy), 32'(1'b0));
    check_frame("t5_b0", n0,     8'h2A, 1'b0);
    check_frame("t5_b1", n0 + 1, 8'hAA, 1'b1);
    check_frame("t5_b2", n0 + 2, 8'h55, 1'b1);

    // 3: host inhibit during bit 3 of the second byte
    repeat (20) @(negedge clk);
    n0 = rx_frames.size();
    a0 = abort_cnt;
    d0 = done_cnt;
    send(9'h003, 9'h000, 3'b000, "t3");
    wait_falls(14, 400, "t3");
    k = 0;
    for (int i = 0; i < 20 && !ps2c_w; i++) @(negedge clk);
    host_c_low = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (m_abort_tick) begin
        k = i;
        break;
      end
    end
    check("t3_abort_at", 32'(k), 32'(4));
    check("t3_d_rel", 32'(ps2d_w), 32'(1'b1));
    check("t3_busy_abort", 32'(m_busy), 32'(1'b0));
    host_c_low = 1'b0;
    repeat (100) @(negedge clk);
    check("t3_abort_once", 32'(abort_cnt - a0), 32'(1));
    check("t3_no_done",    32'(done_cnt - d0),  32'(0));
    check("t3_c_rel", 32'(ps2c_w), 32'(1'b1));
    check("t3_nframes", 32'(rx_frames.size() - n0), 32'(1));

    // 4: host holds clock low before the packet; first start bit GAP cycles after release
    host_c_low = 1'b1;
    repeat (5) @(negedge clk);
    n0 = rx_frames.size();
    send(9'h001, 9'h001, 3'b000, "t4");
    repeat (60) @(negedge clk);
    check("t4_busy_wait", 32'(m_busy), 32'(1'b1));
    check("t4_d_wait",    32'(ps2d_w), 32'(1'b1));
    host_c_low = 1'b0;
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (!ps2d_w) begin
        k = i;
        break;
      end
    end
    check("t4_start_lat", 32'(k), 32'(8));
    wait_done(600, "t4");
    check("t4_nframes", 32'(rx_frames.size() - n0), 32'(3));
    check_frame("t4_b0", n0,     8'h08, 1'b0);
    check_frame("t4_b2", n0 + 2, 8'h01, 1'b0);

    // 6: asynchronous reset in the middle of the third byte
    repeat (20) @(negedge clk);
    n0 = rx_frames.size();
    a0 = abort_cnt;
    d0 = done_cnt;
    send(9'h010, 9'h020, 3'b000, "t6");
    wait_falls(25, 600, "t6");
    check("t6_c_low",  32'(ps2c_w), 32'(1'b0));
    check("t6_d_low",  32'(ps2d_w), 32'(1'b0));
    reset = 1'b0;
    #1;
    check("t6_c_rel",  32'(ps2c_w), 32'(1'b1));
    check("t6_d_rel",  32'(ps2d_w), 32'(1'b1));
    check("t6_busy",   32'(m_busy), 32'(1'b0));
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (100) @(negedge clk);
    check("t6_idle_busy", 32'(m_busy), 32'(1'b0));
    check("t6_nframes",   32'(rx_frames.size() - n0), 32'(2));
    check("t6_no_done",   32'(done_cnt - d0), 32'(0));
    check("t6_no_abort",  32'(abort_cnt - a0), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
